// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and width helpers for the RAM-backed FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 64;
    localparam int c_DEFAULT_DEPTH      = 16;

    // Pointer width: address bits plus one wrap bit
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Occupancy width: must hold Depth+1 (RAM entries plus output stage)
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/DualPortRam.sv
`default_nettype none
// ============================================================================
// Module      : DualPortRam
// Description : Simple dual-port RAM, one write port and one registered read
//               port. RData holds its value while REnc is low.
// Revision    : 1.0 - initial release
// ============================================================================
module DualPortRam #(
    parameter int DataWidth = 64,
    parameter int Deepth    = 16,
    localparam int AddrWidth = $clog2(Deepth)
) (
    input  logic                 WClk,
    input  logic                 WEnc,
    input  logic [AddrWidth-1:0] WAddr,
    input  logic [DataWidth-1:0] WData,
    input  logic                 RClk,
    input  logic                 REnc,
    input  logic [AddrWidth-1:0] RAddr,
    output logic [DataWidth-1:0] RData
);

    logic [DataWidth-1:0] r_mem [Deepth];

    // Write port: store payload on enable
    always_ff @(posedge WClk) begin
        if (WEnc) begin
            r_mem[WAddr] <= WData;
        end
    end

    // Read port: registered read, output held when not enabled
    always_ff @(posedge RClk) begin
        if (REnc) begin
            RData <= r_mem[RAddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : Synchronous show-ahead FIFO controller around one DualPortRam.
//               The RAM read register acts as the output stage, so Count
//               covers RAM entries plus the entry presented on OutData.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DataWidth = c_DEFAULT_DATA_WIDTH,
    parameter int Depth     = c_DEFAULT_DEPTH,
    localparam int AddrWidth = $clog2(Depth),
    localparam int PtrWidth  = ptr_width(Depth),
    localparam int CntWidth  = cnt_width(Depth)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Flush,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [DataWidth-1:0] InData,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DataWidth-1:0] OutData,
    output logic [CntWidth-1:0]  Count,
    output logic                 Empty,
    output logic                 Full
);

    logic [PtrWidth-1:0] r_wr_ptr;
    logic [PtrWidth-1:0] r_rd_ptr;
    logic                r_out_valid;

    logic [PtrWidth-1:0] w_ram_cnt;
    logic                w_push;
    logic                w_pop;
    logic                w_rd_issue;
    logic                w_wenc;
    logic                w_renc;

    // Wrap bit keeps full (difference == Depth) distinct from empty (== 0)
    assign w_ram_cnt = r_wr_ptr - r_rd_ptr;
    assign Full      = (w_ram_cnt == PtrWidth'(Depth));
    assign InReady   = !Full;

    assign w_push     = InValid && InReady;
    assign w_pop      = r_out_valid && OutReady;
    // Refill the output stage whenever it is empty or being drained this cycle
    assign w_rd_issue = (w_ram_cnt != '0) && (!r_out_valid || w_pop);

    // A flush drops both handshakes, so the RAM is left untouched that cycle
    assign w_wenc = w_push && !Flush;
    assign w_renc = w_rd_issue && !Flush;

    assign OutValid = r_out_valid;
    assign Count    = {1'b0, w_ram_cnt} + {{(CntWidth-1){1'b0}}, r_out_valid};
    assign Empty    = (Count == '0);

    // Pointer and output-stage state; flush has priority over traffic
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
        end else if (Flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    DualPortRam #(
        .DataWidth (DataWidth),
        .Deepth    (Depth)
    ) u_ram (
        .WClk  (Clk),
        .WEnc  (w_wenc),
        .WAddr (r_wr_ptr[AddrWidth-1:0]),
        .WData (InData),
        .RClk  (Clk),
        .REnc  (w_renc),
        .RAddr (r_rd_ptr[AddrWidth-1:0]),
        .RData (OutData)
    );

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_fifo_ctrl
// Description : Self-checking bench for ram_fifo_ctrl, compared against a
//               queue-based model (RAM queue plus one output slot).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    localparam int DW    = 64;
    localparam int DEPTH = 16;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Flush;
    logic          InValid;
    logic          InReady;
    logic [DW-1:0] InData;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] OutData;
    logic [5:0]    Count;
    logic          Empty;
    logic          Full;

    int errors = 0;
    int checks = 0;

    // Reference model: words stored in RAM, plus the presented head word
    logic [DW-1:0] m_ram[$];
    bit            m_outv;
    logic [DW-1:0] m_outd;

    ram_fifo_ctrl #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .Count    (Count),
        .Empty    (Empty),
        .Full     (Full)
    );

    always #5 Clk = ~Clk;

    // Advance the model by one edge using the current inputs, then clock
    task automatic tick();
        bit psh, pp, iss;
        psh = InValid && (m_ram.size() < DEPTH);
        pp  = m_outv && OutReady;
        iss = (m_ram.size() != 0) && (!m_outv || pp);
        if (Flush) begin
            m_ram.delete();
            m_outv = 1'b0;
        end else begin
            if (iss) begin
                m_outd = m_ram.pop_front();
                m_outv = 1'b1;
            end else if (pp) begin
                m_outv = 1'b0;
            end
            if (psh) m_ram.push_back(InData);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Rst = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0; InData = '0;
        m_ram.delete();
        m_outv = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (Count !== 6'd0)   begin errors++; $display("FAIL reset_count: got %0d want 0", Count); end
        checks++; if (Empty !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b want 1", Empty); end
        checks++; if (Full !== 1'b0)    begin errors++; $display("FAIL reset_full: got %b want 0", Full); end
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready: got %b want 1", InReady); end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
    endtask

    task automatic test_single();
        apply_reset();
        InValid = 1'b1; InData = 64'hA5;
        tick();
        InValid = 1'b0;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL single_latency: OutValid got %b want 0", OutValid); end
        tick();
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", OutValid); end
        checks++; if (Count !== 6'd1)    begin errors++; $display("FAIL single_count: got %0d want 1", Count); end
        checks++; if (Empty !== 1'b0)    begin errors++; $display("FAIL single_empty: got %b want 0", Empty); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (OutValid !== 1'b1 || OutData !== 64'hA5) begin
                errors++; $display("FAIL single_stall%0d: valid=%b data=%h want 1/a5", i, OutValid, OutData);
            end
            tick();
        end
    endtask

    task automatic test_fill();
        int exp_idx;
        int budget;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            InValid = 1'b1; InData = DW'(i);
            tick();
        end
        InData = DW'(17);
        checks++; if (Count !== 6'd17)   begin errors++; $display("FAIL fill_count: got %0d want 17", Count); end
        checks++; if (Full !== 1'b1)     begin errors++; $display("FAIL fill_full: got %b want 1", Full); end
        checks++; if (InReady !== 1'b0)  begin errors++; $display("FAIL fill_inready: got %b want 0", InReady); end
        checks++; if (OutData !== 64'd0) begin errors++; $display("FAIL fill_head: got %h want 0", OutData); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (Count !== 6'd17)   begin errors++; $display("FAIL fill_blocked: count got %0d want 17", Count); end
        OutReady = 1'b1;
        exp_idx = 0;
        budget = 0;
        while (exp_idx < 18 && budget < 60) begin
            bit acc;
            if (OutValid) begin
                checks++;
                if (OutData !== DW'(exp_idx)) begin
                    errors++; $display("FAIL fill_order: got %h want %h", OutData, DW'(exp_idx));
                end
                exp_idx++;
            end
            acc = InValid && InReady;
            tick();
            if (acc) InValid = 1'b0;
            budget++;
        end
        checks++; if (exp_idx != 18) begin errors++; $display("FAIL fill_drain_timeout: got %0d words want 18", exp_idx); end
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL fill_final_empty: got %b want 1", Empty); end
        OutReady = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        InValid = 1'b1; OutReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            InData = DW'(i);
            tick();
            if (i >= 1) begin
                checks++;
                if (OutValid !== 1'b1 || OutData !== DW'(i - 1)) begin
                    errors++; $display("FAIL stream_%0d: valid=%b data=%h want 1/%h", i, OutValid, OutData, DW'(i - 1));
                end
            end else begin
                checks++;
                if (OutValid !== 1'b0) begin errors++; $display("FAIL stream_latency: OutValid got %b want 0", OutValid); end
            end
        end
        InValid = 1'b0; OutReady = 1'b0;
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            InValid = 1'b1; InData = DW'(100 + i);
            tick();
        end
        checks++; if (Count !== 6'd10) begin errors++; $display("FAIL flush_prefill: count got %0d want 10", Count); end
        Flush = 1'b1; InValid = 1'b1; OutReady = 1'b1; InData = 64'hDEAD;
        tick();
        Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        checks++; if (Count !== 6'd0)    begin errors++; $display("FAIL flush_count: got %0d want 0", Count); end
        checks++; if (Empty !== 1'b1)    begin errors++; $display("FAIL flush_empty: got %b want 1", Empty); end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_outvalid: got %b want 0", OutValid); end
        tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_dropped_push: OutValid got %b want 0", OutValid); end
        InValid = 1'b1; InData = 64'h77;
        tick();
        InValid = 1'b0;
        tick();
        checks++;
        if (OutValid !== 1'b1 || OutData !== 64'h77) begin
            errors++; $display("FAIL flush_next_word: valid=%b data=%h want 1/77", OutValid, OutData);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            InValid = 1'b1; InData = DW'(200 + i);
            tick();
        end
        InValid = 1'b0;
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL areset_pre: OutValid got %b want 1", OutValid); end
        #2;
        Rst = 1'b0;
        #1;
        m_ram.delete();
        m_outv = 1'b0;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL areset_outvalid: got %b want 0", OutValid); end
        checks++; if (Count !== 6'd0)    begin errors++; $display("FAIL areset_count: got %0d want 0", Count); end
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        InValid = 1'b1; InData = 64'h3C;
        tick();
        InValid = 1'b0;
        tick();
        checks++;
        if (OutValid !== 1'b1 || OutData !== 64'h3C) begin
            errors++; $display("FAIL areset_readback: valid=%b data=%h want 1/3c", OutValid, OutData);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 10000; c++) begin
            InValid  = 1'($urandom_range(0, 1));
            OutReady = 1'($urandom_range(0, 1));
            InData   = {$urandom(), $urandom()};
            tick();
            checks++;
            if (Count !== 6'(m_ram.size() + int'(m_outv))) begin
                errors++; $display("FAIL rand_count@%0d: got %0d want %0d", c, Count, m_ram.size() + int'(m_outv));
            end
            checks++;
            if (OutValid !== m_outv || (m_outv && OutData !== m_outd)) begin
                errors++; $display("FAIL rand_head@%0d: valid=%b data=%h want %b/%h", c, OutValid, OutData, m_outv, m_outd);
            end
            checks++;
            if (InReady !== (m_ram.size() < DEPTH) || Full !== (m_ram.size() == DEPTH)) begin
                errors++; $display("FAIL rand_flags@%0d: inready=%b full=%b ram=%0d", c, InReady, Full, m_ram.size());
            end
            checks++;
            if (Full && Empty) begin
                errors++; $display("FAIL rand_full_empty@%0d: full=%b empty=%b want not both 1", c, Full, Empty);
            end
        end
        InValid = 1'b0; OutReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
